// File: rtl/rvc_asap_pkg.sv
// Shared types for the D_MEM arbiter: grant/response owner encoding and streak counter width.
// Imported by rvc_arb_streak_cnt and rvc_dmem_arb_5pl.
package rvc_asap_pkg;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_EXT  = 2'd2
  } t_arb_owner;

  localparam int ARB_STREAK_W = 4;

endpackage : rvc_asap_pkg

// File: rtl/rvc_arb_streak_cnt.sv
// Saturating count of consecutive core grants taken while the external requester waits.
// o_at_max tells the arbiter to force the external request through on this cycle.
module rvc_arb_streak_cnt
  import rvc_asap_pkg::*;
#(
  parameter int SAT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [ARB_STREAK_W-1:0] SAT_V = ARB_STREAK_W'(SAT);

  logic [ARB_STREAK_W-1:0] r_streak;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_streak <= '0;
    end else if (i_clr) begin
      r_streak <= '0;
    end else if (i_inc && (r_streak != SAT_V)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign o_at_max = (r_streak == SAT_V);

endmodule : rvc_arb_streak_cnt

// File: rtl/rvc_dmem_arb_5pl.sv
// D_MEM port arbiter between the 5-stage core (Q103H request / Q104H data) and an external
// valid/ready requester. Define RVC_DMEM_ARB_PERF_EN to add grant/stall performance counters.
module rvc_dmem_arb_5pl
  import rvc_asap_pkg::*;
#(
  parameter int MAX_CORE_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // core, Q103H request / Q104H data
  input  logic              i_core_req_q103h,
  input  logic              i_core_wr_en_q103h,
  input  logic [ADDR_W-1:0] i_core_addr_q103h,
  input  logic [31:0]       i_core_wr_data_q103h,
  input  logic [3:0]        i_core_byte_en_q103h,
  output logic              o_core_stall,
  output logic [31:0]       o_core_rd_data_q104h,
  // external requester
  input  logic              i_ext_req_valid,
  output logic              o_ext_req_ready,
  input  logic              i_ext_wr_en,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [31:0]       i_ext_wr_data,
  input  logic [3:0]        i_ext_byte_en,
  output logic              o_ext_rsp_valid,
  output logic [31:0]       o_ext_rd_data,
  // D_MEM port
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wr_data,
  output logic [3:0]        o_mem_byte_en,
  output logic              o_mem_wr_en,
  output logic              o_mem_rd_en,
  input  logic [31:0]       i_mem_rd_data
`ifdef RVC_DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       o_perf_ext_grant_cnt,
  output logic [31:0]       o_perf_core_stall_cnt
`endif
);

  t_arb_owner  w_grant;
  t_arb_owner  w_rsp_owner_nxt;
  t_arb_owner  r_rsp_owner;
  logic        w_at_max;
  logic        w_ext_rsp;
  logic [31:0] r_ext_rd_data;

  rvc_arb_streak_cnt #(
    .SAT (MAX_CORE_STREAK)
  ) u_streak (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    ((w_grant == ARB_CORE) && i_ext_req_valid),
    .i_clr    ((w_grant == ARB_EXT) || !i_ext_req_valid),
    .o_at_max (w_at_max)
  );

  // Grant is held at NONE while in reset so every strobe shows its reset value.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant         = ARB_NONE;
    w_rsp_owner_nxt = ARB_NONE;
    o_mem_addr      = '0;
    o_mem_wr_data   = '0;
    o_mem_byte_en   = '0;
    o_mem_wr_en     = 1'b0;
    o_mem_rd_en     = 1'b0;
    if (!i_rst) begin
      if (i_ext_req_valid && (!i_core_req_q103h || w_at_max)) begin
        w_grant = ARB_EXT;
      end else if (i_core_req_q103h) begin
        w_grant = ARB_CORE;
      end
    end
    case (w_grant)
      ARB_CORE: begin
        o_mem_addr      = i_core_addr_q103h;
        o_mem_wr_data   = i_core_wr_data_q103h;
        o_mem_byte_en   = i_core_byte_en_q103h;
        o_mem_wr_en     = i_core_wr_en_q103h;
        o_mem_rd_en     = !i_core_wr_en_q103h;
        w_rsp_owner_nxt = i_core_wr_en_q103h ? ARB_NONE : ARB_CORE;
      end
      ARB_EXT: begin
        o_mem_addr      = i_ext_addr;
        o_mem_wr_data   = i_ext_wr_data;
        o_mem_byte_en   = i_ext_byte_en;
        o_mem_wr_en     = i_ext_wr_en;
        o_mem_rd_en     = !i_ext_wr_en;
        w_rsp_owner_nxt = i_ext_wr_en ? ARB_NONE : ARB_EXT;
      end
      default: ;
    endcase
  end

  assign o_ext_req_ready = (w_grant == ARB_EXT);
  assign o_core_stall    = i_core_req_q103h && (w_grant == ARB_EXT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_owner   <= ARB_NONE;
      r_ext_rd_data <= '0;
    end else begin
      r_rsp_owner <= w_rsp_owner_nxt;
      if (r_rsp_owner == ARB_EXT) begin
        r_ext_rd_data <= i_mem_rd_data;
      end
    end
  end

  // A reset landing on the response cycle drops the pending Ext response.
  assign w_ext_rsp            = !i_rst && (r_rsp_owner == ARB_EXT);
  assign o_ext_rsp_valid      = w_ext_rsp;
  assign o_ext_rd_data        = i_rst ? '0 : (w_ext_rsp ? i_mem_rd_data : r_ext_rd_data);
  assign o_core_rd_data_q104h = i_mem_rd_data;

`ifdef RVC_DMEM_ARB_PERF_EN
  logic [31:0] r_perf_ext_grant_cnt;
  logic [31:0] r_perf_core_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_ext_grant_cnt  <= '0;
      r_perf_core_stall_cnt <= '0;
    end else begin
      if (w_grant == ARB_EXT) r_perf_ext_grant_cnt <= r_perf_ext_grant_cnt + 32'd1;
      if (o_core_stall)       r_perf_core_stall_cnt <= r_perf_core_stall_cnt + 32'd1;
    end
  end

  assign o_perf_ext_grant_cnt  = r_perf_ext_grant_cnt;
  assign o_perf_core_stall_cnt = r_perf_core_stall_cnt;
`endif

endmodule : rvc_dmem_arb_5pl
